clock_display_scan: RTL

- Downstream consumer of the BCD minute/second counters and the hour counter.
- Time-multiplexes six BCD digits (HH:MM:SS) onto one 7-segment bus with per-digit anode select.
- Adds frame-coherent input snapshot, hour leading-zero blanking, setting-mode field blink and invalid-BCD indication.
- Sits between the time-keeping counters and the board display pins.

---
 rtl/clock_display_scan.sv | 125 ++++++++++++
 1 files changed

// File: rtl/clock_display_scan.sv
// Six-digit HH:MM:SS multiplexed 7-segment scanner with frame snapshot,
// hour leading-zero blanking, field blink and dash for invalid BCD nibbles.
module clock_display_scan #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       CP,
    input  logic       reset,
    input  logic       EN,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic [1:0] blink_sel,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_start
);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [5:0] AN_POL  = {6{AN_ACTIVE_LOW}};

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         digit_idx_q, digit_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [23:0]        snap_q, snap_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [5:0]         an_q, an_d;
    logic               fs_q, fs_d;

    logic        tick, wrap, blank;
    logic [3:0]  nib;
    logic [1:0]  field;
    logic [6:0]  seg_log;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h40;
        endcase
    endfunction

    always_comb begin
        tick = EN && (scan_cnt_q == SCAN_LAST);
        wrap = tick && (digit_idx_q == 3'd5);

        scan_cnt_d = scan_cnt_q;
        if (EN) scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SCAN_W'(1);

        blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;

        digit_idx_d = digit_idx_q;
        if (tick) digit_idx_d = wrap ? 3'd0 : digit_idx_q + 3'd1;

        // On the wrap edge digit 0 is decoded straight from the live inputs.
        snap_d = wrap ? {hour, minute, second} : snap_q;

        nib = snap_d[4*digit_idx_d +: 4];
        case (digit_idx_d)
            3'd0, 3'd1: field = 2'b11;
            3'd2, 3'd3: field = 2'b10;
            default:    field = 2'b01;
        endcase
        blank = (blink_phase_q && blink_sel != 2'b00 && blink_sel == field)
             || (lz_blank && digit_idx_d == 3'd5 && snap_d[23:20] == 4'd0);
        seg_log = blank ? 7'h00 : bcd_to_seg(nib);

        seg_d = seg_q;
        dp_d  = dp_q;
        an_d  = an_q;
        if (tick) begin
            seg_d = seg_log ^ SEG_POL;
            dp_d  = (digit_idx_d == 3'd2 || digit_idx_d == 3'd4) ^ SEG_ACTIVE_LOW;
            an_d  = (6'd1 << digit_idx_d) ^ AN_POL;
        end
        fs_d = wrap;
    end

    always_ff @(posedge CP) begin
        if (reset) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= 3'd5;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_q        <= 24'h0;
            seg_q         <= SEG_POL;
            dp_q          <= SEG_ACTIVE_LOW;
            an_q          <= AN_POL;
            fs_q          <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_q        <= snap_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            fs_q          <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;
endmodule
